// File: rtl/morse_char_decoder.sv
// Morse sequence decoder: FIFO-buffered 10-bit symbol sequences decoded to ASCII
// through a two-stage pipeline (decode register, output register) with valid/ready output.
module morse_char_decoder #(
    parameter int          DEPTH        = 4,
    parameter logic [7:0]  UNKNOWN_CHAR = 8'h3F
) (
    input  logic                     clk,
    input  logic                     Reset_n,
    input  logic                     Clear,
    input  logic [9:0]               seq_in,
    input  logic                     seq_valid,
    input  logic                     char_ready,
    output logic [7:0]               char_out,
    output logic                     char_valid,
    output logic                     char_err,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     o_dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Handshake: char_out/char_err transfer on a rising edge where char_valid and
    // char_ready are both high; while char_valid=1 and char_ready=0 they hold.

    logic [9:0]     r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_count;
    logic           r_overflow;

    logic           r_d_valid;
    logic [7:0]     r_d_char;
    logic           r_d_err;

    state_t         r_state;
    logic [7:0]     r_char_out;
    logic           r_char_err;
    logic           r_char_valid;

    logic           w_full;
    logic           w_empty;
    logic           w_o_load;
    logic           w_d_load;
    logic           w_pop;
    logic           w_push;
    logic [8:0]     w_dec;

    // Returns {err, ascii}. Symbols are shifted in MSB-first as dash=1, so the
    // lookup key is {length, pattern} with the first symbol leftmost.
    function automatic logic [8:0] decode(input logic [9:0] seq);
        logic [1:0] sym;
        logic       gap;
        logic       bad;
        logic       hit;
        logic [2:0] len;
        logic [4:0] bits;
        logic [7:0] ch;
        gap  = 1'b0;
        bad  = 1'b0;
        hit  = 1'b1;
        len  = 3'd0;
        bits = 5'd0;
        for (int k = 0; k < 5; k++) begin
            sym = seq[9-2*k -: 2];
            if (sym == 2'b11) begin
                bad = 1'b1;
            end else if (sym == 2'b00) begin
                gap = 1'b1;
            end else if (gap) begin
                bad = 1'b1;
            end else begin
                len  = len + 3'd1;
                bits = {bits[3:0], sym[1]};
            end
        end
        case ({len, bits})
            8'b000_00000: ch = 8'h20;
            8'b001_00000: ch = "E";
            8'b001_00001: ch = "T";
            8'b010_00000: ch = "I";
            8'b010_00001: ch = "A";
            8'b010_00010: ch = "N";
            8'b010_00011: ch = "M";
            8'b011_00000: ch = "S";
            8'b011_00001: ch = "U";
            8'b011_00010: ch = "R";
            8'b011_00011: ch = "W";
            8'b011_00100: ch = "D";
            8'b011_00101: ch = "K";
            8'b011_00110: ch = "G";
            8'b011_00111: ch = "O";
            8'b100_00000: ch = "H";
            8'b100_00001: ch = "V";
            8'b100_00010: ch = "F";
            8'b100_00100: ch = "L";
            8'b100_00110: ch = "P";
            8'b100_00111: ch = "J";
            8'b100_01000: ch = "B";
            8'b100_01001: ch = "X";
            8'b100_01010: ch = "C";
            8'b100_01011: ch = "Y";
            8'b100_01100: ch = "Z";
            8'b100_01101: ch = "Q";
            8'b101_00000: ch = "5";
            8'b101_00001: ch = "4";
            8'b101_00011: ch = "3";
            8'b101_00111: ch = "2";
            8'b101_01111: ch = "1";
            8'b101_11111: ch = "0";
            8'b101_11110: ch = "9";
            8'b101_11100: ch = "8";
            8'b101_11000: ch = "7";
            8'b101_10000: ch = "6";
            default: begin
                ch  = UNKNOWN_CHAR;
                hit = 1'b0;
            end
        endcase
        if (bad) begin
            ch = UNKNOWN_CHAR;
        end
        return {bad || !hit, ch};
    endfunction

    assign w_full   = (r_count == FULL_LVL);
    assign w_empty  = (r_count == '0);
    assign w_dec    = decode(r_mem[r_rd_ptr]);

    // Backward flow: each stage may load when it is empty or drains this cycle.
    assign w_o_load = r_d_valid && ((r_state == ST_IDLE) || char_ready);
    assign w_d_load = !w_empty && (!r_d_valid || w_o_load);
    assign w_pop    = w_d_load;
    assign w_push   = seq_valid && !Clear && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= seq_in;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (Clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (seq_valid && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_d_valid <= 1'b0;
            r_d_char  <= 8'h00;
            r_d_err   <= 1'b0;
        end else if (Clear) begin
            r_d_valid <= 1'b0;
        end else if (w_d_load) begin
            r_d_valid <= 1'b1;
            r_d_char  <= w_dec[7:0];
            r_d_err   <= w_dec[8];
        end else if (w_o_load) begin
            r_d_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= ST_IDLE;
            r_char_out   <= 8'h00;
            r_char_err   <= 1'b0;
            r_char_valid <= 1'b0;
        end else if (Clear) begin
            r_state      <= ST_IDLE;
            r_char_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_d_valid) begin
                        r_state      <= ST_PRESENT;
                        r_char_out   <= r_d_char;
                        r_char_err   <= r_d_err;
                        r_char_valid <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (char_ready) begin
                        if (r_d_valid) begin
                            r_char_out <= r_d_char;
                            r_char_err <= r_d_err;
                        end else begin
                            r_state      <= ST_IDLE;
                            r_char_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_char_valid <= 1'b0;
                end
            endcase
        end
    end

    assign char_out    = r_char_out;
    assign char_err    = r_char_err;
    assign char_valid  = r_char_valid;
    assign overflow    = r_overflow;
    assign fifo_level  = r_count;
    assign o_dbg_state = (r_state == ST_PRESENT);

endmodule

// File: tb/tb_morse_char_decoder.sv
// Bench for morse_char_decoder: directed sequences built from dot/dash strings,
// expected characters queued at issue and checked by an independent output monitor.
module tb_morse_char_decoder;

    logic       clk = 1'b0;
    logic       Reset_n;
    logic       Clear;
    logic [9:0] seq_in;
    logic       seq_valid;
    logic       char_ready;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_err;
    logic       overflow;
    logic [2:0] fifo_level;
    logic       dbg_state;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];
    string morse_tab [0:35];

    morse_char_decoder #(.DEPTH(4), .UNKNOWN_CHAR(8'h3F)) dut (
        .clk         (clk),
        .Reset_n     (Reset_n),
        .Clear       (Clear),
        .seq_in      (seq_in),
        .seq_valid   (seq_valid),
        .char_ready  (char_ready),
        .char_out    (char_out),
        .char_valid  (char_valid),
        .char_err    (char_err),
        .overflow    (overflow),
        .fifo_level  (fifo_level),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] enc(input string s);
        logic [9:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) begin
            r[9-2*i -: 2] = (s[i] == 8'h2D) ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    function automatic logic [8:0] exp_of(input int idx);
        if (idx < 26) return {1'b0, 8'(8'h41 + idx)};
        return {1'b0, 8'(8'h30 + idx - 26)};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] s, input logic [8:0] exp, input bit accept);
        seq_in    = s;
        seq_valid = 1'b1;
        if (accept) exp_q.push_back(exp);
        tick();
        seq_valid = 1'b0;
    endtask

    // scoreboard monitor
    initial begin : monitor
        logic       stall;
        logic [8:0] held;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (!Reset_n) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    check("hold_valid", char_valid, 1);
                    check("hold_data", {char_err, char_out}, held);
                end
                if (char_valid && char_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_char: got %0h expected none", {char_err, char_out});
                    end else begin
                        check("char", {char_err, char_out}, exp_q.pop_front());
                    end
                end
                stall = char_valid && !char_ready && !Clear;
                held  = {char_err, char_out};
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        morse_tab = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                      "..-", "...-", ".--", "-..-", "-.--", "--..",
                      "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                      "---..", "----."};
        Reset_n = 1'b0; Clear = 1'b0; seq_in = '0; seq_valid = 1'b0; char_ready = 1'b0;
        #2;
        check("rst_valid", char_valid, 0);
        check("rst_char", char_out, 0);
        check("rst_err", char_err, 0);
        check("rst_ovf", overflow, 0);
        check("rst_level", fifo_level, 0);
        check("rst_state", dbg_state, 0);
        tick(); tick();
        Reset_n = 1'b1;
        tick();

        // single decode latency
        char_ready = 1'b1;
        seq_in = 10'b0110000000; seq_valid = 1'b1; exp_q.push_back({1'b0, 8'h41});
        tick();
        seq_valid = 1'b0;
        @(negedge clk); check("lat_n0_valid", char_valid, 0); check("lat_n0_level", fifo_level, 1);
        tick(); @(negedge clk); check("lat_n1_valid", char_valid, 0);
        tick(); @(negedge clk); check("lat_n2_valid", char_valid, 1);
        tick(); @(negedge clk); check("one_cycle", char_valid, 0);
        tick();

        // table sweep, back-to-back
        for (int i = 0; i < 36; i++) send(enc(morse_tab[i]), exp_of(i), 1'b1);
        send(10'b0000000000, {1'b0, 8'h20}, 1'b1);
        send(10'b0111010000, {1'b1, 8'h3F}, 1'b1);
        send(10'b0001000000, {1'b1, 8'h3F}, 1'b1);
        send(10'b1100000000, {1'b1, 8'h3F}, 1'b1);
        send(10'b0101101000, {1'b1, 8'h3F}, 1'b1);
        tick(); tick();
        @(negedge clk); #1;
        check("sweep_drained", exp_q.size(), 0);
        tick();

        // backpressure fills FIFO + both stages
        char_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(enc(morse_tab[10+i]), exp_of(10+i), 1'b1);
        @(negedge clk);
        check("bp_level", fifo_level, 4);
        check("bp_ovf0", overflow, 0);
        check("bp_valid", char_valid, 1);
        check("bp_head", char_out, 8'h4B);
        tick();
        send(enc("..."), {1'b0, 8'h53}, 1'b0);
        send(enc("-"), {1'b0, 8'h54}, 1'b0);
        @(negedge clk);
        check("bp_ovf1", overflow, 1);
        check("bp_level_full", fifo_level, 4);
        tick();
        char_ready = 1'b1;
        repeat (8) tick();
        @(negedge clk); #1;
        check("bp_drained", exp_q.size(), 0);
        check("bp_ovf_sticky", overflow, 1);
        check("bp_level_empty", fifo_level, 0);
        tick();
        Clear = 1'b1; tick(); Clear = 1'b0;
        @(negedge clk); check("bp_ovf_cleared", overflow, 0);

        // full FIFO with simultaneous push and pop
        tick();
        char_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(enc(morse_tab[i]), exp_of(i), 1'b1);
        char_ready = 1'b1;
        send(enc("--.."), {1'b0, 8'h5A}, 1'b1);
        @(negedge clk);
        check("fpp_level", fifo_level, 4);
        check("fpp_ovf", overflow, 0);
        tick();
        repeat (8) tick();
        @(negedge clk); #1;
        check("fpp_drained", exp_q.size(), 0);
        tick();

        // clear with level 3 and overflow set
        char_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(enc(morse_tab[26+i]), exp_of(26+i), 1'b1);
        send(enc("----."), {1'b0, 8'h39}, 1'b0);
        char_ready = 1'b1;
        tick();
        char_ready = 1'b0;
        @(negedge clk);
        check("clr_pre_level", fifo_level, 3);
        check("clr_pre_ovf", overflow, 1);
        tick();
        Clear = 1'b1; seq_in = enc("."); seq_valid = 1'b1;
        tick();
        Clear = 1'b0; seq_valid = 1'b0;
        @(negedge clk);
        check("clr_level", fifo_level, 0);
        check("clr_valid", char_valid, 0);
        check("clr_ovf", overflow, 0);
        exp_q.delete();
        tick();
        char_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("clr_quiet_valid", char_valid, 0);
        check("clr_quiet_level", fifo_level, 0);

        // asynchronous reset mid-traffic
        tick();
        char_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(enc(morse_tab[i]), exp_of(i), 1'b1);
        check("mid_pre_valid", char_valid, 1);
        Reset_n = 1'b0;
        #1;
        check("mid_rst_valid", char_valid, 0);
        check("mid_rst_char", char_out, 0);
        check("mid_rst_err", char_err, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_ovf", overflow, 0);
        exp_q.delete();
        @(negedge clk);
        tick();
        Reset_n = 1'b1;
        char_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check("mid_quiet_valid", char_valid, 0);
        check("mid_quiet_level", fifo_level, 0);
        tick();
        send(enc("-.-."), {1'b0, 8'h43}, 1'b1);
        repeat (3) tick();
        @(negedge clk); #1;
        check("post_rst_drained", exp_q.size(), 0);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/morse_char_decoder.md
# morse_char_decoder

Downstream consumer of the sequence storage stage. Accepts 10-bit encoded Morse sequences (five 2-bit symbols) with a one-cycle strobe, buffers them in a small FIFO, decodes each into an 8-bit ASCII character and presents it on a valid/ready output for the display/UART stage. It runs on the same divided clock as the storage stage.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- UNKNOWN_CHAR, 8'h3F, ASCII emitted for undecodable sequences ('?')
- clk  in  1  divided system clock; all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Clear  in  1  synchronous flush of FIFO, pipeline and sticky flags
- seq_in  in  10  encoded sequence; symbol k at bits [9-2k:8-2k], k=0 first
- seq_valid  in  1  one-cycle strobe; seq_in is captured on this edge
- char_ready  in  1  downstream accepts char_out when high with char_valid
- char_out  out  8  decoded ASCII character
- char_valid  out  1  char_out valid
- char_err  out  1  qualifies char_out: sequence was undecodable
- overflow  out  1  sticky: a seq_valid arrived while FIFO full
- fifo_level  out  $clog2(DEPTH)+1  entries currently in FIFO

## Operation
- Symbol code: 00 none, 01 dot, 10 dash, 11 illegal.
- A well-formed sequence is zero or more non-00 symbols from k=0, followed only by 00 symbols.
- Decode: standard ITU Morse for A-Z (1-4 symbols) and 0-9 (5 symbols), uppercase ASCII.
- All-zero sequence decodes to 8'h20 (word space), char_err=0.
- Any 11 symbol, any non-00 after a 00, or a well-formed pattern not in the table -> UNKNOWN_CHAR, char_err=1.
- FIFO: circular buffer, read/write pointers with wrap; push on seq_valid when not full.
- Push while full: entry dropped, overflow set; except when a pop happens that same cycle, in which case the push is accepted.
- Pipeline: FIFO head -> decode register (stage D) -> output register (stage O). Items advance when the next stage is empty or is draining in the same cycle; no bubbles under continuous char_ready=1.
- Output FSM states: IDLE (char_valid=0), PRESENT (char_valid=1). IDLE->PRESENT when stage D holds an item; PRESENT->IDLE on char_ready with nothing in D; PRESENT->PRESENT (new char) on char_ready with D occupied.
- char_out/char_err held stable while char_valid=1 and char_ready=0.
- Clear: empties FIFO and both stages, char_valid=0, overflow=0, next cycle; a seq_valid coincident with Clear is discarded.

## Timing
- Reset (Reset_n low, asynchronous): char_out=8'h00, char_valid=0, char_err=0, overflow=0, fifo_level=0, pointers=0, FSM IDLE.
- Reset deasserts synchronously in effect: first capture on the first rising edge with Reset_n high.
- Latency: seq_valid at edge N into an empty block -> char_valid high after edge N+2.
- Throughput: one character per cycle when char_ready held high.
- fifo_level updates the cycle after push/pop; push+pop same cycle leaves it unchanged.
- Reset mid-operation discards all buffered sequences; no partial character is emitted after release.

## Test plan
- Reset: drive Reset_n low mid-traffic -> all outputs at reset values immediately; no char_valid after release until new seq_valid.
- Single decode: seq_in=10'b0110000000 (dot,dash) with char_ready=1 -> char_out=8'h41 ('A'), char_err=0, char_valid high exactly one cycle, 2 cycles after strobe.
- Table sweep: all 26 letters, 10 digits, all-zero -> correct ASCII; 10'b0111_0100_00 (illegal 11) and 10'b0001000000 (gap then dot) -> 8'h3F, char_err=1.
- Backpressure: char_ready=0, send 6 sequences back-to-back -> FIFO fills to 4, pipeline holds 2 (stage D, stage O), further strobes set overflow; char_out stable; release char_ready -> 6 chars in order, none duplicated.
- Full push+pop: FIFO full, char_ready=1 and seq_valid same cycle -> push accepted, overflow stays 0, fifo_level unchanged.
- Clear: with FIFO at level 3 and overflow=1, pulse Clear with coincident seq_valid -> next cycle fifo_level=0, char_valid=0, overflow=0, no characters emitted afterward.
